// File: rtl/motor_pkg.sv
// Shared state encodings and default parameters for the motor PWM driver.
package motor_pkg;

   typedef enum logic [1:0] {
      ST_OFF       = 2'b00,
      ST_RAMP_UP   = 2'b01,
      ST_ON        = 2'b10,
      ST_RAMP_DOWN = 2'b11
   } motor_state_t;

   localparam int DEF_PWM_BITS     = 8;
   localparam int DEF_PRESCALE     = 195;
   localparam int DEF_DUTY_MAX     = 255;
   localparam int DEF_RAMP_STEP    = 1;
   localparam int DEF_RAMP_PERIODS = 4;

endpackage

// File: rtl/pwm_core.sv
// PWM timebase: prescaler, free-running period counter and registered duty comparator.
// period_end flags the last tick of each PWM period so duty updates land on cnt=0.
module pwm_core
   import motor_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PWM_BITS-1:0] duty,
   output logic                pwm_out,
   output logic                period_end
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1'b1);
   localparam logic [PS_W-1:0]     PS_ZERO  = {PS_W{1'b0}};
   localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1'b1);
   localparam logic [PWM_BITS-1:0] CNT_ZERO = {PWM_BITS{1'b0}};

   logic [PS_W-1:0]     presc_r;
   logic [PWM_BITS-1:0] cnt_r;
   logic                pwm_r;
   logic                pwm_tick_s;

   assign pwm_tick_s = (presc_r == PS_LAST);
   assign period_end = pwm_tick_s && (cnt_r == CNT_LAST);
   assign pwm_out    = pwm_r;

   // Prescaler, period counter and registered comparator (one clk lag from cnt).
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_r <= PS_ZERO;
         cnt_r   <= CNT_ZERO;
         pwm_r   <= 1'b0;
      end else begin
         if (pwm_tick_s) begin
            presc_r <= PS_ZERO;
            cnt_r   <= cnt_r + CNT_ONE;
         end else begin
            presc_r <= presc_r + PS_ONE;
         end
         pwm_r <= (cnt_r < duty);
      end
   end

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor H-bridge driver: soft-start / soft-stop duty ramp FSM on top of pwm_core.
// Duty only moves on a ramp step, which always coincides with a PWM period boundary.
module motor_pwm_driver
   import motor_pkg::*;
#(
   parameter int PWM_BITS     = DEF_PWM_BITS,
   parameter int PRESCALE     = DEF_PRESCALE,
   parameter int DUTY_MAX     = DEF_DUTY_MAX,
   parameter int RAMP_STEP    = DEF_RAMP_STEP,
   parameter int RAMP_PERIODS = DEF_RAMP_PERIODS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                motor_on,
   output logic                pwm_out,
   output logic                bridge_en,
   output logic [PWM_BITS-1:0] duty,
   output logic                at_speed,
   output logic                stopped
);

   localparam int RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [RC_W-1:0]     RC_LAST  = RC_W'(RAMP_PERIODS - 1);
   localparam logic [RC_W-1:0]     RC_ONE   = RC_W'(1'b1);
   localparam logic [RC_W-1:0]     RC_ZERO  = {RC_W{1'b0}};
   localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(RAMP_STEP);
   localparam logic [PWM_BITS:0]   DMAX_W   = (PWM_BITS + 1)'(DUTY_MAX);
   localparam logic [PWM_BITS-1:0] DMAX_N   = PWM_BITS'(DUTY_MAX);
   localparam logic [PWM_BITS-1:0] DUTY_Z   = {PWM_BITS{1'b0}};

   motor_state_t        state_r, state_nx_s;
   logic [PWM_BITS-1:0] duty_r, duty_nx_s;
   logic [RC_W-1:0]     ramp_cnt_r, ramp_cnt_nx_s;
   logic                bridge_en_r, at_speed_r, stopped_r;
   logic                bridge_en_nx_s, at_speed_nx_s, stopped_nx_s;
   logic                period_end_s, ramping_s, ramp_step_s;
   logic [PWM_BITS:0]   sum_up_s, sum_dn_s;
   logic [PWM_BITS-1:0] duty_up_s, duty_dn_s;

   pwm_core #(
      .PWM_BITS (PWM_BITS),
      .PRESCALE (PRESCALE)
   ) u_pwm_core (
      .clk        (clk),
      .reset      (reset),
      .duty       (duty_r),
      .pwm_out    (pwm_out),
      .period_end (period_end_s)
   );

   assign duty      = duty_r;
   assign bridge_en = bridge_en_r;
   assign at_speed  = at_speed_r;
   assign stopped   = stopped_r;

   // State, duty, ramp counter and status flags register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_OFF;
         duty_r      <= DUTY_Z;
         ramp_cnt_r  <= RC_ZERO;
         bridge_en_r <= 1'b0;
         at_speed_r  <= 1'b0;
         stopped_r   <= 1'b1;
      end else begin
         state_r     <= state_nx_s;
         duty_r      <= duty_nx_s;
         ramp_cnt_r  <= ramp_cnt_nx_s;
         bridge_en_r <= bridge_en_nx_s;
         at_speed_r  <= at_speed_nx_s;
         stopped_r   <= stopped_nx_s;
      end
   end

   // Ramp pacing and saturating duty arithmetic (borrow bit flags underflow).
   always_comb begin
      ramping_s   = (state_r == ST_RAMP_UP) || (state_r == ST_RAMP_DOWN);
      ramp_step_s = ramping_s && period_end_s && (ramp_cnt_r == RC_LAST);
      if (!ramping_s) begin
         ramp_cnt_nx_s = RC_ZERO;
      end else if (ramp_step_s) begin
         ramp_cnt_nx_s = RC_ZERO;
      end else if (period_end_s) begin
         ramp_cnt_nx_s = ramp_cnt_r + RC_ONE;
      end else begin
         ramp_cnt_nx_s = ramp_cnt_r;
      end
      sum_up_s = {1'b0, duty_r} + STEP_W;
      sum_dn_s = {1'b0, duty_r} - STEP_W;
      if (sum_up_s >= DMAX_W) begin
         duty_up_s = DMAX_N;
      end else begin
         duty_up_s = sum_up_s[PWM_BITS-1:0];
      end
      if (sum_dn_s[PWM_BITS]) begin
         duty_dn_s = DUTY_Z;
      end else begin
         duty_dn_s = sum_dn_s[PWM_BITS-1:0];
      end
   end

   // Next-state: a motor_on reversal takes priority over reaching the end value.
   always_comb begin
      state_nx_s = ST_OFF;
      case (state_r)
         ST_OFF: begin
            if (motor_on) state_nx_s = ST_RAMP_UP;
            else          state_nx_s = ST_OFF;
         end
         ST_RAMP_UP: begin
            if (!motor_on)                               state_nx_s = ST_RAMP_DOWN;
            else if (ramp_step_s && duty_up_s == DMAX_N) state_nx_s = ST_ON;
            else                                         state_nx_s = ST_RAMP_UP;
         end
         ST_ON: begin
            if (!motor_on) state_nx_s = ST_RAMP_DOWN;
            else           state_nx_s = ST_ON;
         end
         ST_RAMP_DOWN: begin
            if (motor_on)                                state_nx_s = ST_RAMP_UP;
            else if (ramp_step_s && duty_dn_s == DUTY_Z) state_nx_s = ST_OFF;
            else                                         state_nx_s = ST_RAMP_DOWN;
         end
         default: state_nx_s = ST_OFF;
      endcase
   end

   // Outputs: a step always follows the current state's direction.
   always_comb begin
      duty_nx_s = DUTY_Z;
      case (state_r)
         ST_OFF:       duty_nx_s = DUTY_Z;
         ST_RAMP_UP: begin
            if (ramp_step_s) duty_nx_s = duty_up_s;
            else             duty_nx_s = duty_r;
         end
         ST_ON:        duty_nx_s = DMAX_N;
         ST_RAMP_DOWN: begin
            if (ramp_step_s) duty_nx_s = duty_dn_s;
            else             duty_nx_s = duty_r;
         end
         default:      duty_nx_s = DUTY_Z;
      endcase
      bridge_en_nx_s = (state_nx_s != ST_OFF);
      at_speed_nx_s  = (state_nx_s == ST_ON);
      stopped_nx_s   = (state_nx_s == ST_OFF);
   end

endmodule
